// File: rtl/game_pkg.sv
// Shared encodings for the Connect4 engine: controller state, game status and checker verdicts.
package game_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StTurn  = 2'b01,
    StCheck = 2'b10,
    StEnd   = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    StatPlaying = 2'b00,
    StatWin     = 2'b01,
    StatTie     = 2'b10,
    StatIdle    = 2'b11
  } status_e;

  localparam logic [1:0] ChkNext = 2'b00;
  localparam logic [1:0] ChkWin  = 2'b01;
  localparam logic [1:0] ChkTie  = 2'b10;
  localparam logic [1:0] ChkRsvd = 2'b11;

endpackage

// File: rtl/turn_timer.sv
// Per-turn cycle counter: clears on i_clear, counts on i_en, flags the last cycle and wraps there.
module turn_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_d;

  assign o_expire = i_en & (r_cnt == CntLast);

  always_comb begin
    w_cnt_d = r_cnt;
    if (i_clear) begin
      w_cnt_d = '0;
    end else if (i_en) begin
      w_cnt_d = o_expire ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_d;
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Game-flow controller for 2..4 players with valid/ready move intake and checker verdict wait.
// Optional turn-timeout skip enabled by defining TURN_TIMEOUT_EN.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PID_W       = 2,
  parameter int unsigned MOVE_CNT_W  = 6,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  move_valid,
  input  logic [PID_W-1:0]      move_pid,
  output logic                  move_ready,
  output logic                  move_illegal,
  input  logic                  chk_valid,
  input  logic [1:0]            chk_result,
  output logic [PID_W-1:0]      cur_player,
  output logic [1:0]            game_status,
  output logic [PID_W-1:0]      winner,
  output logic [MOVE_CNT_W-1:0] move_cnt,
  output logic [1:0]            state
);

  localparam logic [PID_W-1:0] LastPid = PID_W'(NUM_PLAYERS - 1);

  state_e                r_state, w_state_d;
  status_e               r_status, w_status_d;
  logic [PID_W-1:0]      r_cur, w_cur_d;
  logic [PID_W-1:0]      r_winner, w_winner_d;
  logic [MOVE_CNT_W-1:0] r_cnt, w_cnt_d;
  logic                  r_ready, w_ready_d;
  logic                  r_illegal, w_illegal_d;

  logic                  w_xfer;
  logic                  w_expire;
  logic [PID_W-1:0]      w_next_pid;

  assign w_xfer     = move_valid & r_ready;
  assign w_next_pid = (r_cur == LastPid) ? '0 : r_cur + 1'b1;

`ifdef TURN_TIMEOUT_EN
  turn_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_turn_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (r_state != StTurn),
    .i_en    (r_state == StTurn),
    .o_expire(w_expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign w_expire           = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_status_d  = r_status;
    w_cur_d     = r_cur;
    w_winner_d  = r_winner;
    w_cnt_d     = r_cnt;
    w_illegal_d = 1'b0;
    unique case (r_state)
      StIdle, StEnd: begin
        if (start) begin
          w_state_d  = StTurn;
          w_cur_d    = '0;
          w_cnt_d    = '0;
          w_status_d = StatPlaying;
        end
      end
      StTurn: begin
        // A transfer in the expiry cycle wins over the timeout skip.
        if (w_xfer) begin
          if (move_pid == r_cur) begin
            w_state_d = StCheck;
            if (r_cnt != '1) begin
              w_cnt_d = r_cnt + 1'b1;
            end
          end else begin
            w_illegal_d = 1'b1;
          end
        end else if (w_expire) begin
          w_cur_d = w_next_pid;
        end
      end
      StCheck: begin
        if (chk_valid) begin
          case (chk_result)
            ChkWin: begin
              w_state_d  = StEnd;
              w_winner_d = r_cur;
              w_status_d = StatWin;
            end
            ChkTie: begin
              w_state_d  = StEnd;
              w_status_d = StatTie;
            end
            default: begin
              w_state_d = StTurn;
              w_cur_d   = w_next_pid;
            end
          endcase
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_ready_d = (w_state_d == StTurn);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_status  <= StatIdle;
      r_cur     <= '0;
      r_winner  <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_status  <= w_status_d;
      r_cur     <= w_cur_d;
      r_winner  <= w_winner_d;
      r_cnt     <= w_cnt_d;
      r_ready   <= w_ready_d;
      r_illegal <= w_illegal_d;
    end
  end

  assign move_ready   = r_ready;
  assign move_illegal = r_illegal;
  assign cur_player   = r_cur;
  assign game_status  = r_status;
  assign winner       = r_winner;
  assign move_cnt     = r_cnt;
  assign state        = r_state;

endmodule

// File: doc/game_turn_ctrl.md
# game_turn_ctrl

Parametrised game-flow controller for the Connect4 board engine. It supersedes the fixed two-player turn FSM and supports 2–4 players. Moves are accepted from the input stage through a valid/ready handshake, and the controller waits for the win/tie checker's verdict before advancing the turn. It tracks the move count and can optionally skip a player whose turn times out.

## Interface
- NUM_PLAYERS, default 2: number of players, legal range 2..4.
- PID_W, default 2: player-ID width; must satisfy 2**PID_W >= NUM_PLAYERS.
- MOVE_CNT_W, default 6: move-counter width; saturates at all-ones.
- TIMEOUT_CYC, default 1000: clock cycles allowed per turn. Only used when TURN_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; leaves IDLE or END and begins a new game.
- move_valid  in  1  a move is offered by the input stage.
- move_pid  in  PID_W  player offering the move.
- move_ready  out  1  high only in TURN.
- move_illegal  out  1  one-cycle pulse when a handshake completes with move_pid != cur_player.
- chk_valid  in  1  the checker's verdict is valid. Only sampled in CHECK.
- chk_result  in  2  verdict code: 00 NEXT, 01 WIN, 10 TIE, 11 reserved (treated as NEXT).
- cur_player  out  PID_W  player whose turn it is.
- game_status  out  2  00 PLAYING, 01 WIN, 10 TIE, 11 IDLE.
- winner  out  PID_W  winning player; valid when game_status = WIN.
- move_cnt  out  MOVE_CNT_W  number of accepted legal moves in the current game.
- state  out  2  00 IDLE, 01 TURN, 10 CHECK, 11 END.

## Operation
- Reset values: state=IDLE, cur_player=0, game_status=IDLE, winner=0, move_cnt=0, move_ready=0, move_illegal=0.
- IDLE: on start, go to TURN with cur_player=0, move_cnt=0, game_status=PLAYING.
- TURN: on move_valid & move_ready:
  - If move_pid == cur_player: go to CHECK and increment move_cnt (saturating).
  - Otherwise: pulse move_illegal and stay in TURN. The move is consumed and not counted.
- CHECK: move_ready=0. Waits indefinitely for chk_valid.
  - NEXT: go to TURN; cur_player advances to cur_player+1, wrapping from NUM_PLAYERS-1 to 0.
  - WIN: go to END; winner=cur_player, game_status=WIN.
  - TIE: go to END; game_status=TIE. cur_player is unchanged.
- END: all outputs hold. move_valid and chk_valid are ignored. start begins a new game exactly as from IDLE.
- start is ignored in TURN and CHECK.
- Reset at any point, including mid-CHECK, returns all outputs to their reset values. A pending verdict is discarded.

## Timing
- All outputs are registered. state and the other outputs update on the clk edge after the qualifying input.
- Handshake: a transfer occurs in the cycle where move_valid & move_ready are both high. move_ready drops in the next cycle.
- Minimum turn latency is 2 cycles: handshake cycle → CHECK; chk_valid seen in CHECK → TURN.
- chk_valid asserted in the same cycle the controller enters CHECK is not sampled. It is sampled from the first cycle in which state=CHECK.
- move_illegal is high for exactly 1 cycle per illegal transfer.

## Configuration
- TURN_TIMEOUT_EN defined:
  - A per-turn counter clears on entry to TURN and counts while in TURN.
  - When it reaches TIMEOUT_CYC-1 with no transfer in that cycle, cur_player advances (with wrap), the counter clears, and the state stays TURN. move_cnt is unchanged.
  - A transfer in the expiry cycle takes priority over the skip.
- TURN_TIMEOUT_EN undefined: no counter logic. A turn waits forever.

## Structure
- Shared package game_pkg holds the state encoding, the game_status codes and the chk_result codes. The board checker and display blocks use the same package.
- One sub-module, turn_timer: a counter with clear, enable and expire outputs. It is instantiated only under TURN_TIMEOUT_EN.

## Test plan
- Reset then start → state=TURN, cur_player=0, move_cnt=0, game_status=PLAYING.
- NUM_PLAYERS=3: three legal moves, each followed by chk_result=NEXT → cur_player sequence 0,1,2,0; move_cnt=3.
- Player 1 offers a move during player 0's turn → move_illegal high for 1 cycle, state=TURN, move_cnt unchanged.
- Player 1 moves, then chk_result=WIN → state=END, game_status=01, winner=1. A later move_valid is ignored. start → new game with cur_player=0.
- Reset asserted while in CHECK with chk_valid high → all outputs return to reset values and state=IDLE.
- TURN_TIMEOUT_EN with TIMEOUT_CYC=8: idle for 8 cycles in TURN → cur_player 0→1, move_cnt unchanged. A transfer in cycle 8 → state=CHECK instead of the skip.
